sprite_pixel_decoder: RTL and testbench

Pipelined, parametrised pixel-to-object decoder for the frame renderer. It sits between the VGA timing generator and the SRAM/ROM fetch logic. For each VGA pixel it decides whether the pixel shows the map, the status bar, or one of NUM_SPRITES sprites, and returns the object ID and the pixel index within that object. Sprite positions are double-buffered per frame, and a per-frame sprite-collision report is produced.

---
 rtl/sprite_pixel_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_sprite_pixel_decoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_decoder.sv
// sprite_pixel_decoder: maps each VGA pixel to the map, the status bar or a
// sprite, with per-frame double-buffered sprite state and collision report.
module sprite_pixel_decoder #(
    parameter int NUM_SPRITES = 2,
    parameter int MAP_H       = 1600,
    parameter int MAP_V       = 800,
    parameter int SCREEN_V    = 900,
    parameter int IMAGE_SIZE  = 64,
    parameter int H_WIDTH     = 11,
    parameter int V_WIDTH     = 10,
    parameter int ID_WIDTH    = $clog2(NUM_SPRITES + 2)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_frame_start,
    input  logic [NUM_SPRITES*H_WIDTH-1:0]               i_sprite_x,
    input  logic [NUM_SPRITES*V_WIDTH-1:0]               i_sprite_y,
    input  logic [NUM_SPRITES-1:0]                       i_sprite_en,
    input  logic [NUM_SPRITES*IMAGE_SIZE*IMAGE_SIZE-1:0] i_opacity_mask,
    input  logic                                         i_valid,
    input  logic [H_WIDTH-1:0]                           i_VGA_H,
    input  logic [V_WIDTH-1:0]                           i_VGA_V,
    output logic                                         o_valid,
    output logic [ID_WIDTH-1:0]                          o_object_id,
    output logic [H_WIDTH+V_WIDTH-1:0]                   o_object_pixel_index,
    output logic [NUM_SPRITES-1:0]                       o_collision,
    output logic                                         o_collision_valid
);

    localparam int HW    = H_WIDTH + 2;
    localparam int VW    = V_WIDTH + 2;
    localparam int IW    = H_WIDTH + V_WIDTH;
    localparam int SQ    = IMAGE_SIZE * IMAGE_SIZE;
    localparam int PW    = $clog2(SQ);
    localparam int H_OFF = (MAP_H - IMAGE_SIZE) / 2 + 1;
    localparam int V_OFF = (MAP_V - IMAGE_SIZE) / 2 + 1;

    logic [NUM_SPRITES*H_WIDTH-1:0] sh_x;
    logic [NUM_SPRITES*V_WIDTH-1:0] sh_y;
    logic [NUM_SPRITES-1:0]         sh_en;

    // shadow sprite state, swapped in only at the frame boundary
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_en <= '0;
        end else if (i_frame_start) begin
            sh_x  <= i_sprite_x;
            sh_y  <= i_sprite_y;
            sh_en <= i_sprite_en;
        end
    end

    logic               p0_valid;
    logic [H_WIDTH-1:0] p0_h;
    logic [V_WIDTH-1:0] p0_v;

    // coordinate register; loads on the same edge as the shadow, so a pixel
    // coincident with the frame pulse is decoded against the new positions
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            p0_valid <= 1'b0;
            p0_h     <= '0;
            p0_v     <= '0;
        end else begin
            p0_valid <= i_valid;
            p0_h     <= i_VGA_H;
            p0_v     <= i_VGA_V;
        end
    end

    // relative column/row of the pixel inside each sprite box (two's complement)
    logic [NUM_SPRITES-1:0][HW-1:0] col_c;
    logic [NUM_SPRITES-1:0][VW-1:0] row_c;

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_rel
        logic [H_WIDTH-1:0] xk;
        logic [V_WIDTH-1:0] yk;
        assign xk = sh_x[k*H_WIDTH +: H_WIDTH];
        assign yk = sh_y[k*V_WIDTH +: V_WIDTH];
        assign col_c[k] = {2'b00, p0_h} - {{2{xk[H_WIDTH-1]}}, xk} - HW'(H_OFF);
        assign row_c[k] = {2'b00, p0_v} + {{2{yk[V_WIDTH-1]}}, yk} - VW'(V_OFF);
    end

    logic                           s1_valid;
    logic                           s1_map;
    logic                           s1_bar;
    logic [H_WIDTH-1:0]             s1_h;
    logic [V_WIDTH-1:0]             s1_v;
    logic [NUM_SPRITES-1:0]         s1_en;
    logic [NUM_SPRITES-1:0][HW-1:0] s1_col;
    logic [NUM_SPRITES-1:0][VW-1:0] s1_row;

    // stage 1 register: region flags and per-sprite relative position
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_map   <= 1'b0;
            s1_bar   <= 1'b0;
            s1_h     <= '0;
            s1_v     <= '0;
            s1_en    <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= p0_valid;
            s1_map   <= p0_v <= V_WIDTH'(MAP_V);
            s1_bar   <= p0_v > V_WIDTH'(MAP_V) && p0_v <= V_WIDTH'(SCREEN_V);
            s1_h     <= p0_h;
            s1_v     <= p0_v;
            s1_en    <= sh_en;
            s1_col   <= col_c;
            s1_row   <= row_c;
        end
    end

    // negative offsets read as large unsigned values, so one compare clips both sides
    logic [NUM_SPRITES-1:0]         hit_c;
    logic [NUM_SPRITES-1:0][PW-1:0] lin_c;

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_hit
        logic [SQ-1:0] mk;
        logic          in_box;
        assign mk       = i_opacity_mask[k*SQ +: SQ];
        assign in_box   = s1_col[k] < HW'(IMAGE_SIZE) && s1_row[k] < VW'(IMAGE_SIZE);
        assign lin_c[k] = PW'(s1_row[k]) * PW'(IMAGE_SIZE) + PW'(s1_col[k]);
        assign hit_c[k] = s1_valid && s1_map && s1_en[k] && in_box && mk[lin_c[k]];
    end

    logic                           s2_valid;
    logic                           s2_bar;
    logic [H_WIDTH-1:0]             s2_h;
    logic [V_WIDTH-1:0]             s2_v;
    logic [NUM_SPRITES-1:0]         s2_hit;
    logic [NUM_SPRITES-1:0][PW-1:0] s2_lin;

    // stage 2 register: per-sprite opaque hit and linear sprite index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_bar   <= 1'b0;
            s2_h     <= '0;
            s2_v     <= '0;
            s2_hit   <= '0;
            s2_lin   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_bar   <= s1_bar;
            s2_h     <= s1_h;
            s2_v     <= s1_v;
            s2_hit   <= hit_c;
            s2_lin   <= lin_c;
        end
    end

    // map and bar share one row*MAP_H multiplier; only the row origin differs
    logic [IW-1:0] row_off;
    logic [IW-1:0] area_idx;
    assign row_off  = s2_bar ? IW'(MAP_V + 1) : IW'(1);
    assign area_idx = (IW'(s2_v) - row_off) * IW'(MAP_H) + IW'(s2_h) - IW'(1);

    logic [ID_WIDTH-1:0] id_c;
    logic [IW-1:0]       idx_c;

    // priority select: bar, else lowest-index opaque sprite, else map
    always_comb begin
        id_c  = '0;
        idx_c = area_idx;
        if (s2_bar) begin
            id_c = ID_WIDTH'(1);
        end else begin
            for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
                if (s2_hit[k]) begin
                    id_c  = ID_WIDTH'(k + 2);
                    idx_c = IW'(s2_lin[k]);
                end
            end
        end
    end

    // sprites involved in an overlap on this pixel (empty unless two or more hit)
    logic [NUM_SPRITES-1:0] multi_c;
    assign multi_c = (|(s2_hit & (s2_hit - NUM_SPRITES'(1)))) ? s2_hit : '0;

    // output register; id/index hold their last value on idle cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid              <= 1'b0;
            o_object_id          <= '0;
            o_object_pixel_index <= '0;
        end else begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_object_id          <= id_c;
                o_object_pixel_index <= idx_c;
            end
        end
    end

    logic [NUM_SPRITES-1:0] coll_acc;

    // per-frame collision accumulator, reported and cleared at the frame pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            coll_acc          <= '0;
            o_collision       <= '0;
            o_collision_valid <= 1'b0;
        end else begin
            o_collision_valid <= i_frame_start;
            if (i_frame_start) begin
                o_collision <= coll_acc | multi_c;
                coll_acc    <= '0;
            end else begin
                coll_acc <= coll_acc | multi_c;
            end
        end
    end

endmodule

// File: tb/tb_sprite_pixel_decoder.sv
// Bench for sprite_pixel_decoder: directed and random pixels checked by a
// scoreboard fed from a behavioural model of the decode rules.
module tb_sprite_pixel_decoder;

    localparam int NS = 2;
    localparam int IS = 64;
    localparam int SQ = IS * IS;

    logic              clk = 1'b0;
    logic              rst;
    logic              fs;
    logic [NS*11-1:0]  sx;
    logic [NS*10-1:0]  sy;
    logic [NS-1:0]     sen;
    logic [NS*SQ-1:0]  mask;
    logic              valid;
    logic [10:0]       h;
    logic [9:0]        v;
    logic              o_valid;
    logic [1:0]        o_id;
    logic [20:0]       o_idx;
    logic [NS-1:0]     o_coll;
    logic              o_coll_valid;

    sprite_pixel_decoder dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_frame_start        (fs),
        .i_sprite_x           (sx),
        .i_sprite_y           (sy),
        .i_sprite_en          (sen),
        .i_opacity_mask       (mask),
        .i_valid              (valid),
        .i_VGA_H              (h),
        .i_VGA_V              (v),
        .o_valid              (o_valid),
        .o_object_id          (o_id),
        .o_object_pixel_index (o_idx),
        .o_collision          (o_coll),
        .o_collision_valid    (o_coll_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     id;
        int     idx;
        longint cyc;
    } exp_t;

    exp_t          q[$];
    logic [NS-1:0] cq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    longint        cyc = 0;
    bit            mon_on = 1'b0;

    int            mx[NS];
    int            my[NS];
    bit            men[NS];
    logic [NS-1:0] acc;

    always @(posedge clk) cyc <= cyc + 1;

    // reference: object and index straight from the box/priority rules
    function automatic void ref_pix(input int ph, input int pv, output int id,
                                    output int idx, output logic [NS-1:0] hits);
        int hmin;
        int vmin;
        hits = '0;
        if (pv > 800) begin
            id  = 1;
            idx = (pv - 801) * 1600 + ph - 1;
            return;
        end
        id  = 0;
        idx = (pv - 1) * 1600 + ph - 1;
        for (int k = NS - 1; k >= 0; k--) begin
            hmin = mx[k] + (1600 - IS) / 2 + 1;
            vmin = -my[k] + (800 - IS) / 2 + 1;
            if (men[k] && ph >= hmin && ph < hmin + IS && pv >= vmin && pv < vmin + IS
                && mask[k * SQ + (pv - vmin) * IS + (ph - hmin)]) begin
                hits[k] = 1'b1;
                id      = k + 2;
                idx     = (pv - vmin) * IS + (ph - hmin);
            end
        end
    endfunction

    // one clock of stimulus; eid < 0 means take the expectation from the model
    task automatic step(input bit r, input bit f, input bit pv, input int ph,
                        input int pvv, input int eid = -1, input int eidx = -1);
        int            id;
        int            idx;
        logic [NS-1:0] hits;
        exp_t          e;
        rst   = r;
        fs    = f;
        valid = pv;
        h     = 11'(ph);
        v     = 10'(pvv);
        if (r) begin
            q.delete();
            cq.delete();
            acc = '0;
            for (int k = 0; k < NS; k++) begin
                mx[k] = 0; my[k] = 0; men[k] = 1'b0;
            end
        end else begin
            if (f) begin
                cq.push_back(acc);
                acc = '0;
                for (int k = 0; k < NS; k++) begin
                    mx[k]  = int'($signed(sx[k*11 +: 11]));
                    my[k]  = int'($signed(sy[k*10 +: 10]));
                    men[k] = sen[k];
                end
            end
            if (pv) begin
                ref_pix(ph, pvv, id, idx, hits);
                if ($countones(hits) >= 2) acc = acc | hits;
                e.id  = (eid >= 0) ? eid : id;
                e.idx = (eid >= 0) ? eidx : idx;
                e.cyc = cyc + 4;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1);
    endtask

    task automatic pulse();
        idle(4);
        step(0, 1, 0, 1, 1);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_spr(input int k, input int x, input int y);
        sx[k*11 +: 11] = 11'(x);
        sy[k*10 +: 10] = 10'(y);
    endtask

    exp_t          mon_e;
    logic [NS-1:0] mon_c;

    // monitor: pop and compare whenever the DUT presents a result
    always @(negedge clk) begin
        if (mon_on && o_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL pixel: got unexpected o_valid id=%0d idx=%0d, expected none",
                         o_id, o_idx);
            end else begin
                mon_e = q.pop_front();
                if (int'(o_id) != mon_e.id || int'(o_idx) != mon_e.idx || cyc != mon_e.cyc) begin
                    n_bad++;
                    $display("FAIL pixel: got id=%0d idx=%0d cyc=%0d, expected id=%0d idx=%0d cyc=%0d",
                             o_id, o_idx, cyc, mon_e.id, mon_e.idx, mon_e.cyc);
                end
            end
        end
        if (mon_on && o_coll_valid) begin
            n_cmp++;
            if (cq.size() == 0) begin
                n_bad++;
                $display("FAIL collision: got unexpected pulse value=%b, expected none", o_coll);
            end else begin
                mon_c = cq.pop_front();
                if (o_coll != mon_c) begin
                    n_bad++;
                    $display("FAIL collision: got %b, expected %b", o_coll, mon_c);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fs = 1'b0; valid = 1'b0; h = 11'd1; v = 10'd1;
        sx = '0; sy = '0; sen = '0; mask = '1;
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        mon_on = 1'b1;
        chk("rst_valid", o_valid, 0);
        chk("rst_id", o_id, 0);
        chk("rst_idx", o_idx, 0);
        chk("rst_coll", o_coll, 0);
        chk("rst_coll_valid", o_coll_valid, 0);

        // map and bar corners
        idle(1);
        step(0, 0, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1600, 800, 0, 799 * 1600 + 1599);
        step(0, 0, 1, 1, 801, 1, 0);
        idle(4);

        // sprite 0 corners, fully opaque
        set_spr(0, 0, 0); set_spr(1, 0, 0); sen = 2'b01;
        pulse();
        step(0, 0, 1, 769, 369, 2, 0);
        step(0, 0, 1, 832, 432, 2, 63 * 64 + 63);
        step(0, 0, 1, 768, 369, 0, (369 - 1) * 1600 + (768 - 1));
        idle(4);

        // priority, transparency, collision, back-to-back pulses
        sen = 2'b11; mask[0] = 1'b0;
        pulse();
        step(0, 0, 1, 769, 369, 3, 0);
        step(0, 0, 1, 770, 369, 2, 1);
        idle(4);
        step(0, 1, 0, 1, 1);
        chk("coll_first", o_coll, 2'b11);
        chk("coll_first_valid", o_coll_valid, 1);
        step(0, 1, 0, 1, 1);
        chk("coll_second", o_coll, 0);
        chk("coll_second_valid", o_coll_valid, 1);
        idle(1);
        chk("coll_valid_drop", o_coll_valid, 0);
        mask = '1;

        // clipping on the left edge and a fully off-screen sprite
        sen = 2'b01; set_spr(0, -800, 0);
        pulse();
        step(0, 0, 1, 1, 369, 2, 32);
        set_spr(0, 900, 0);
        pulse();
        step(0, 0, 1, 1600, 369, 0, 368 * 1600 + 1599);
        step(0, 0, 1, 1, 369, 0, 368 * 1600);
        idle(4);

        // double buffering and pulse bypass
        set_spr(0, 0, 0);
        pulse();
        set_spr(0, 10, 0);
        step(0, 0, 1, 769, 369, 2, 0);
        step(0, 0, 1, 779, 369, 2, 10);
        idle(4);
        step(0, 1, 1, 779, 369, 2, 0);
        step(0, 0, 1, 769, 369, 0, 368 * 1600 + 768);
        idle(4);

        // randomized rounds against the model
        for (int rd = 0; rd < 6; rd++) begin
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(3) == 0)
                    set_spr(k, int'($urandom_range(2047)) - 1024, int'($urandom_range(1023)) - 512);
                else
                    set_spr(k, int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100);
            end
            sen = 2'($urandom_range(3));
            if (rd > 3) sen = 2'b11;
            for (int i = 0; i < NS * SQ / 32; i++) mask[i*32 +: 32] = $urandom() | $urandom();
            pulse();
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(9) == 0)
                    idle(1);
                else if ($urandom_range(1) == 0)
                    step(0, 0, 1, int'($urandom_range(900, 670)), int'($urandom_range(480, 260)));
                else
                    step(0, 0, 1, int'($urandom_range(1600, 1)), int'($urandom_range(900, 1)));
            end
            idle(4);
        end
        pulse();

        // reset in the middle of a pixel burst
        mask = '1; sen = 2'b11; set_spr(0, 0, 0); set_spr(1, 0, 0);
        pulse();
        step(0, 0, 1, 770, 369, 2, 1);
        idle(4);
        step(0, 1, 0, 1, 1);
        chk("pre_rst_coll", o_coll, 2'b11);
        idle(4);
        step(0, 0, 1, 770, 369);
        step(0, 0, 1, 771, 369);
        step(1, 0, 1, 772, 369);
        step(1, 0, 1, 773, 369);
        step(1, 0, 1, 774, 369);
        idle(5);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_id", o_id, 0);
        chk("midrst_idx", o_idx, 0);
        chk("midrst_coll", o_coll, 0);
        chk("midrst_coll_valid", o_coll_valid, 0);
        step(0, 0, 1, 770, 369, 0, 368 * 1600 + 769);
        pulse();
        step(0, 0, 1, 770, 369, 2, 1);

        for (int i = 0; i < 20 && (q.size() != 0 || cq.size() != 0); i++) idle(1);
        idle(3);
        chk("sb_drain", q.size() + cq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
